// File: rtl/id_stage_hz.sv
// Decode stage: field/immediate extraction, control decode, bypassed register file, load-use detect, ID/EX register.
// Latency: one cycle from instruction_d1 to idex_* outputs; register write-back lands at the edge, visible same cycle via bypass.
// Backpressure: hold freezes ID/EX and raises stall; load-use inserts one bubble; flush squashes ID and overrides both.
module id_stage_hz #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int RW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     instruction_d1,
   input  logic [XLEN-1:0] pc_d,
   input  logic            flush,
   input  logic            hold,
   input  logic            reg_write_c4wb,
   input  logic [RW-1:0]   rd_c4wb,
   input  logic [XLEN-1:0] write_data_c4wb,
   output logic            stall,
   output logic            idex_valid,
   output logic [XLEN-1:0] idex_pc,
   output logic [RW-1:0]   idex_rs1,
   output logic [RW-1:0]   idex_rs2,
   output logic [RW-1:0]   idex_rd,
   output logic [2:0]      idex_funct3,
   output logic [6:0]      idex_funct7,
   output logic [XLEN-1:0] idex_rdata1,
   output logic [XLEN-1:0] idex_rdata2,
   output logic [XLEN-1:0] idex_imm,
   output logic            idex_alu_src,
   output logic            idex_mem_to_reg,
   output logic            idex_reg_write,
   output logic            idex_mem_read,
   output logic            idex_mem_write,
   output logic            idex_branch,
   output logic            idex_jump,
   output logic            idex_illegal,
   output logic [1:0]      idex_alu_op
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [RW-1:0]   rs1;
      logic [RW-1:0]   rs2;
      logic [RW-1:0]   rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] rdata1;
      logic [XLEN-1:0] rdata2;
      logic [XLEN-1:0] imm;
      logic            alu_src;
      logic            mem_to_reg;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            illegal;
      logic [1:0]      alu_op;
   } idex_t;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   idex_t           idex_q, idex_d, dec;
   logic [6:0]      opcode;
   logic [31:0]     imm32;
   logic            use_rs1, use_rs2, load_use, wb_en;

   assign opcode = instruction_d1[6:0];
   assign wb_en  = reg_write_c4wb && (rd_c4wb != '0);

   // Decode fields, immediate, controls and bypassed operands of the instruction in ID
   always_comb begin
      dec        = '0;
      imm32      = '0;
      dec.valid  = if_valid;
      dec.pc     = pc_d;
      dec.rd     = instruction_d1[7 +: RW];
      dec.funct3 = instruction_d1[14:12];
      dec.rs1    = instruction_d1[15 +: RW];
      dec.rs2    = instruction_d1[20 +: RW];
      case (opcode)
         OP_IALU, OP_LOAD, OP_JALR:
            imm32 = {{20{instruction_d1[31]}}, instruction_d1[31:20]};
         OP_STORE:
            imm32 = {{20{instruction_d1[31]}}, instruction_d1[31:25], instruction_d1[11:7]};
         OP_BRANCH:
            imm32 = {{19{instruction_d1[31]}}, instruction_d1[31], instruction_d1[7],
                     instruction_d1[30:25], instruction_d1[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm32 = {instruction_d1[31:12], 12'b0};
         OP_JAL:
            imm32 = {{11{instruction_d1[31]}}, instruction_d1[31], instruction_d1[19:12],
                     instruction_d1[20], instruction_d1[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
      dec.imm = XLEN'($signed(imm32));
      case (opcode)
         OP_R: begin
            dec.funct7    = instruction_d1[31:25];
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
         end
         OP_IALU: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
         end
         OP_LOAD: begin
            dec.alu_src    = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
         end
         OP_STORE: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu_op = 2'b01;
         end
         OP_JAL: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
         end
         OP_JALR: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // x0 reads zero; a same-cycle write-back to the read index is passed straight through
      if (dec.rs1 == '0)                   dec.rdata1 = '0;
      else if (wb_en && rd_c4wb == dec.rs1) dec.rdata1 = write_data_c4wb;
      else                                 dec.rdata1 = regs_q[dec.rs1];
      if (dec.rs2 == '0)                   dec.rdata2 = '0;
      else if (wb_en && rd_c4wb == dec.rs2) dec.rdata2 = write_data_c4wb;
      else                                 dec.rdata2 = regs_q[dec.rs2];
   end

   // Detect a consumer in ID of a load sitting in ID/EX
   always_comb begin
      use_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
      use_rs2  = (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
      load_use = if_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                 ((use_rs1 && idex_q.rd == dec.rs1) || (use_rs2 && idex_q.rd == dec.rs2));
      stall    = !flush && (hold || load_use);
   end

   // ID/EX next state: flush > hold > load-use bubble > decoded instruction
   always_comb begin
      idex_d = dec;
      if (flush)         idex_d = '0;
      else if (hold)     idex_d = idex_q;
      else if (load_use) idex_d = '0;
   end

   // Register file next state: write-back is never blocked by pipeline control
   always_comb begin
      regs_d = regs_q;
      if (wb_en) regs_d[rd_c4wb] = write_data_c4wb;
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idex_q <= '0;
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         idex_q <= idex_d;
         regs_q <= regs_d;
      end
   end

   assign idex_valid      = idex_q.valid;
   assign idex_pc         = idex_q.pc;
   assign idex_rs1        = idex_q.rs1;
   assign idex_rs2        = idex_q.rs2;
   assign idex_rd         = idex_q.rd;
   assign idex_funct3     = idex_q.funct3;
   assign idex_funct7     = idex_q.funct7;
   assign idex_rdata1     = idex_q.rdata1;
   assign idex_rdata2     = idex_q.rdata2;
   assign idex_imm        = idex_q.imm;
   assign idex_alu_src    = idex_q.alu_src;
   assign idex_mem_to_reg = idex_q.mem_to_reg;
   assign idex_reg_write  = idex_q.reg_write;
   assign idex_mem_read   = idex_q.mem_read;
   assign idex_mem_write  = idex_q.mem_write;
   assign idex_branch     = idex_q.branch;
   assign idex_jump       = idex_q.jump;
   assign idex_illegal    = idex_q.illegal;
   assign idex_alu_op     = idex_q.alu_op;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz: reset, bypass, load-use, immediates, flush/hold, x0 and illegal decode.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns after inputs settle.
// Each scenario task checks its own expectations inline.
module tb_id_stage_hz;
   localparam int XLEN = 32;
   localparam int RW   = 5;

   localparam logic [31:0] I_ADD_4_3_3 = 32'h00318233;
   localparam logic [31:0] I_ADD_6_5_5 = 32'h00528333;
   localparam logic [31:0] I_ADD_4_0_0 = 32'h00000233;
   localparam logic [31:0] I_LW_1_2    = 32'h00012083;
   localparam logic [31:0] I_ADD_5_1_0 = 32'h000082B3;
   localparam logic [31:0] I_LUI_1_1   = 32'h000010B7;
   localparam logic [31:0] I_SW_M4     = 32'hFE112E23;
   localparam logic [31:0] I_BEQ_M8    = 32'hFE000CE3;
   localparam logic [31:0] I_JAL_2048  = 32'h001000EF;
   localparam logic [31:0] I_ILLEGAL   = 32'h0000007F;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_valid;
   logic [31:0]     instruction_d1;
   logic [XLEN-1:0] pc_d;
   logic            flush, hold;
   logic            reg_write_c4wb;
   logic [RW-1:0]   rd_c4wb;
   logic [XLEN-1:0] write_data_c4wb;
   logic            stall, idex_valid;
   logic [XLEN-1:0] idex_pc, idex_rdata1, idex_rdata2, idex_imm;
   logic [RW-1:0]   idex_rs1, idex_rs2, idex_rd;
   logic [2:0]      idex_funct3;
   logic [6:0]      idex_funct7;
   logic            idex_alu_src, idex_mem_to_reg, idex_reg_write, idex_mem_read;
   logic            idex_mem_write, idex_branch, idex_jump, idex_illegal;
   logic [1:0]      idex_alu_op;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   id_stage_hz #(.XLEN(XLEN), .NREGS(32)) dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .instruction_d1(instruction_d1), .pc_d(pc_d),
      .flush(flush), .hold(hold), .reg_write_c4wb(reg_write_c4wb), .rd_c4wb(rd_c4wb),
      .write_data_c4wb(write_data_c4wb), .stall(stall), .idex_valid(idex_valid), .idex_pc(idex_pc),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_funct3(idex_funct3),
      .idex_funct7(idex_funct7), .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
      .idex_imm(idex_imm), .idex_alu_src(idex_alu_src), .idex_mem_to_reg(idex_mem_to_reg),
      .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
      .idex_branch(idex_branch), .idex_jump(idex_jump), .idex_illegal(idex_illegal),
      .idex_alu_op(idex_alu_op)
   );

   // Control bits gathered for the "all controls" checks: alu_src..jump then alu_op
   function automatic logic [8:0] ctl();
      return {idex_alu_src, idex_mem_to_reg, idex_reg_write, idex_mem_read, idex_mem_write,
              idex_branch, idex_jump, idex_alu_op};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
      if_valid       = v;
      instruction_d1 = ins;
      pc_d           = pc;
   endtask

   task automatic test_reset();
      // Put 0x1234 into x5 and load an instruction into ID/EX
      reg_write_c4wb = 1'b1; rd_c4wb = 5'd5; write_data_c4wb = 32'h1234;
      drive(1'b0, 32'h0, 32'h0);
      next_cycle();
      reg_write_c4wb = 1'b0;
      drive(1'b1, I_ADD_6_5_5, 32'h100);
      next_cycle();
      tests_run++;
      if (idex_rdata1 !== 32'h1234 || idex_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL pre_reset_x5: rdata1=%h valid=%b, need 00001234 and 1", idex_rdata1, idex_valid);
      end
      // Asynchronous reset between edges
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({idex_valid, idex_pc, idex_rs1, idex_rs2, idex_rd, idex_funct3, idex_funct7, idex_rdata1,
           idex_rdata2, idex_imm, ctl(), idex_illegal, stall} !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: valid=%b pc=%h rd=%0d rdata1=%h ctl=%b stall=%b, need all 0",
                  idex_valid, idex_pc, idex_rd, idex_rdata1, ctl(), stall);
      end
      next_cycle();
      #2 rst = 1'b0;
      drive(1'b1, I_ADD_6_5_5, 32'h104);
      next_cycle();
      tests_run++;
      if (idex_rdata1 !== 32'h0 || idex_rdata2 !== 32'h0 || idex_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_clears_x5: rdata1=%h rdata2=%h valid=%b, need 0 0 1", idex_rdata1, idex_rdata2, idex_valid);
      end
   endtask

   task automatic test_bypass();
      reg_write_c4wb = 1'b1; rd_c4wb = 5'd3; write_data_c4wb = 32'hDEADBEEF;
      drive(1'b1, I_ADD_4_3_3, 32'h200);
      next_cycle();
      reg_write_c4wb = 1'b0;
      tests_run++;
      if (idex_rdata1 !== 32'hDEADBEEF || idex_rdata2 !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL bypass_data: rdata1=%h rdata2=%h, need deadbeef", idex_rdata1, idex_rdata2);
      end
      tests_run++;
      if (idex_reg_write !== 1'b1 || idex_alu_op !== 2'b10 || idex_rd !== 5'd4 || idex_pc !== 32'h200) begin
         tests_failed++;
         $display("FAIL bypass_ctl: reg_write=%b alu_op=%b rd=%0d pc=%h, need 1 10 4 00000200",
                  idex_reg_write, idex_alu_op, idex_rd, idex_pc);
      end
      // Same instruction again: value now comes from the array
      drive(1'b1, I_ADD_4_3_3, 32'h204);
      next_cycle();
      tests_run++;
      if (idex_rdata1 !== 32'hDEADBEEF || idex_pc !== 32'h204) begin
         tests_failed++;
         $display("FAIL array_read: rdata1=%h pc=%h, need deadbeef 00000204", idex_rdata1, idex_pc);
      end
   endtask

   task automatic test_load_use();
      drive(1'b1, I_LW_1_2, 32'h300);
      next_cycle();
      tests_run++;
      if (idex_mem_read !== 1'b1 || idex_mem_to_reg !== 1'b1 || idex_alu_src !== 1'b1 || idex_alu_op !== 2'b00) begin
         tests_failed++;
         $display("FAIL load_decode: mem_read=%b mem_to_reg=%b alu_src=%b alu_op=%b, need 1 1 1 00",
                  idex_mem_read, idex_mem_to_reg, idex_alu_src, idex_alu_op);
      end
      drive(1'b1, I_ADD_5_1_0, 32'h304);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL load_use_stall: stall=%b, need 1", stall);
      end
      next_cycle();
      tests_run++;
      if (idex_valid !== 1'b0 || stall !== 1'b0 || idex_mem_read !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_use_bubble: valid=%b stall=%b mem_read=%b, need 0 0 0", idex_valid, stall, idex_mem_read);
      end
      next_cycle();
      tests_run++;
      if (idex_valid !== 1'b1 || idex_rs1 !== 5'd1 || idex_pc !== 32'h304) begin
         tests_failed++;
         $display("FAIL load_use_resume: valid=%b rs1=%0d pc=%h, need 1 1 00000304", idex_valid, idex_rs1, idex_pc);
      end
      // lui does not read rs1, so no stall behind a load of x1
      drive(1'b1, I_LW_1_2, 32'h308);
      next_cycle();
      drive(1'b1, I_LUI_1_1, 32'h30C);
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL lui_no_stall: stall=%b, need 0", stall);
      end
      next_cycle();
      tests_run++;
      if (idex_imm !== 32'h00001000 || idex_valid !== 1'b1 || idex_alu_src !== 1'b1) begin
         tests_failed++;
         $display("FAIL lui_decode: imm=%h valid=%b alu_src=%b, need 00001000 1 1", idex_imm, idex_valid, idex_alu_src);
      end
   endtask

   task automatic test_immediates();
      drive(1'b1, I_SW_M4, 32'h400);
      next_cycle();
      tests_run++;
      if (idex_imm !== 32'hFFFFFFFC || ctl() !== 9'b100010000) begin
         tests_failed++;
         $display("FAIL store_imm: imm=%h ctl=%b, need fffffffc 100010000", idex_imm, ctl());
      end
      drive(1'b1, I_BEQ_M8, 32'h404);
      next_cycle();
      tests_run++;
      if (idex_imm !== 32'hFFFFFFF8 || ctl() !== 9'b000001001) begin
         tests_failed++;
         $display("FAIL branch_imm: imm=%h ctl=%b, need fffffff8 000001001", idex_imm, ctl());
      end
      drive(1'b1, I_JAL_2048, 32'h408);
      next_cycle();
      tests_run++;
      if (idex_imm !== 32'h00000800 || ctl() !== 9'b001000100) begin
         tests_failed++;
         $display("FAIL jal_imm: imm=%h ctl=%b, need 00000800 001000100", idex_imm, ctl());
      end
   endtask

   task automatic test_flush_hold();
      drive(1'b1, I_LW_1_2, 32'h500);
      next_cycle();
      drive(1'b1, I_ADD_5_1_0, 32'h504);
      flush = 1'b1;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_load_use_stall: stall=%b, need 0", stall);
      end
      next_cycle();
      flush = 1'b0;
      tests_run++;
      if (idex_valid !== 1'b0 || ctl() !== 9'b0 || idex_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL flush_bubble: valid=%b ctl=%b pc=%h, need 0 0 0", idex_valid, ctl(), idex_pc);
      end
      // Load a known instruction, then hold for three cycles with new input in ID
      drive(1'b1, I_ADD_4_3_3, 32'h510);
      next_cycle();
      drive(1'b1, I_LUI_1_1, 32'h514);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (stall !== 1'b1 || idex_pc !== 32'h510 || idex_rd !== 5'd4 || idex_rdata1 !== 32'hDEADBEEF || idex_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_cycle%0d: stall=%b pc=%h rd=%0d rdata1=%h valid=%b, need 1 00000510 4 deadbeef 1",
                     i, stall, idex_pc, idex_rd, idex_rdata1, idex_valid);
         end
         next_cycle();
      end
      // flush wins over hold
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      hold = 1'b0;
      tests_run++;
      if (idex_valid !== 1'b0 || idex_pc !== 32'h0 || idex_reg_write !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_over_hold: valid=%b pc=%h reg_write=%b, need 0 0 0", idex_valid, idex_pc, idex_reg_write);
      end
   endtask

   task automatic test_x0_and_illegal();
      reg_write_c4wb = 1'b1; rd_c4wb = 5'd0; write_data_c4wb = 32'hFFFFFFFF;
      drive(1'b1, I_ADD_4_0_0, 32'h600);
      next_cycle();
      reg_write_c4wb = 1'b0;
      tests_run++;
      if (idex_rdata1 !== 32'h0 || idex_rdata2 !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_bypass: rdata1=%h rdata2=%h, need 0 0", idex_rdata1, idex_rdata2);
      end
      drive(1'b1, I_ADD_4_0_0, 32'h604);
      next_cycle();
      tests_run++;
      if (idex_rdata1 !== 32'h0 || idex_rdata2 !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_array: rdata1=%h rdata2=%h, need 0 0", idex_rdata1, idex_rdata2);
      end
      drive(1'b1, I_ILLEGAL, 32'h608);
      next_cycle();
      tests_run++;
      if (idex_illegal !== 1'b1 || ctl() !== 9'b0 || idex_imm !== 32'h0 || idex_funct7 !== 7'h0) begin
         tests_failed++;
         $display("FAIL illegal: illegal=%b ctl=%b imm=%h funct7=%h, need 1 0 0 0", idex_illegal, ctl(), idex_imm, idex_funct7);
      end
   endtask

   initial begin
      rst = 1'b1;
      if_valid = 1'b0; instruction_d1 = '0; pc_d = '0;
      flush = 1'b0; hold = 1'b0;
      reg_write_c4wb = 1'b0; rd_c4wb = '0; write_data_c4wb = '0;
      #12 rst = 1'b0;
      next_cycle();
      test_reset();
      test_bypass();
      test_load_use();
      test_immediates();
      test_flush_hold();
      test_x0_and_illegal();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Parametrised decode stage with an integrated ID/EX pipeline register, a register file with write-through bypass, load-use hazard detection and flush/hold control. It sits between the fetch stage and the execute stage of the 5-stage RV32I pipeline. It takes the fetched instruction, the PC and the write-back port, and presents one registered, fully decoded instruction per cycle to EX.

## Interface
- XLEN, 32, datapath width
- NREGS, 32, architectural register count (power of two, ≤32); register index width RW = clog2(NREGS)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  instruction_d1/pc_d hold a real instruction
- instruction_d1  in  32  instruction from IF/ID
- pc_d  in  XLEN  PC of instruction_d1
- flush  in  1  squash the instruction in ID (branch taken in EX)
- hold  in  1  EX not accepting; freeze ID/EX
- reg_write_c4wb  in  1  WB write enable
- rd_c4wb  in  RW  WB destination
- write_data_c4wb  in  XLEN  WB data
- stall  out  1  IF/ID must hold its contents this cycle
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc  out  XLEN  registered PC
- idex_rs1, idex_rs2, idex_rd  out  RW each  register indices
- idex_funct3  out  3;  idex_funct7  out  7 (zero unless opcode 0110011)
- idex_rdata1, idex_rdata2  out  XLEN  operand values
- idex_imm  out  XLEN  sign-extended immediate
- idex_alu_src, idex_mem_to_reg, idex_reg_write, idex_mem_read, idex_mem_write, idex_branch, idex_jump, idex_illegal  out  1 each
- idex_alu_op  out  2

## Operation
- Field extraction and immediates: I for opcodes 0010011/0000011/1100111, S for 0100011, B for 1100011, U for 0110111/0010111, J for 1101111, otherwise 0.
- Control decode: R 0110011 gives reg_write=1 and alu_op=10. I-ALU gives alu_src=1, reg_write=1, alu_op=10. Load gives alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00. Store gives alu_src=1, mem_write=1. Branch gives branch=1 and alu_op=01. JAL/JALR give jump=1 and reg_write=1, with alu_src=1 for JALR. LUI/AUIPC give alu_src=1 and reg_write=1. Any other opcode gives illegal=1 and all other controls 0.
- Register file: NREGS×XLEN. Entry 0 always reads 0 and is never written. It is written on the clock edge when reg_write_c4wb=1 and rd_c4wb≠0. Reads are combinational with write-through: if the read index equals rd_c4wb, is nonzero and reg_write_c4wb=1, the read returns write_data_c4wb.
- Operand use: rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used only by R, S and B.
- Load-use: load_use = if_valid & idex_valid & idex_mem_read & (idex_rd≠0) & ((use_rs1 & idex_rd==rs1) | (use_rs2 & idex_rd==rs2)).
- Per-edge update of ID/EX, in priority order:
  1. rst: everything is cleared.
  2. flush: a bubble is loaded.
  3. hold: contents are unchanged.
  4. load_use: a bubble is loaded.
  5. Otherwise the decoded instruction is loaded, with valid = if_valid.
- A bubble has valid=0, all control bits 0 and data fields 0.
- stall = ~flush & (hold | load_use). This is combinational.
- Write-back is never blocked by flush, hold or stall.

## Timing
- Decode-to-EX latency is 1 cycle. Throughput is 1 instruction/cycle when there is no stall.
- A load-use stall lasts exactly 1 cycle. The next cycle the load has left ID/EX, stall falls and the consumer enters with the value forwarded later by EX/MEM.
- A WB write and a read of the same register in the same cycle gives the new value via bypass. The array itself updates at the edge.
- Reset: all ID/EX outputs are 0 (including idex_valid), all registers are 0, and stall is 0 when hold=0. Asserting rst mid-stall clears ID/EX immediately, without waiting for a clock.
- flush together with load_use: a bubble is loaded and stall=0. flush together with hold: a bubble is loaded (flush wins).

## Test plan
- Reset with x5 previously written to 0x1234: assert rst asynchronously → idex_valid=0, all idex_* outputs 0, and x5 reads 0 afterwards.
- WB writes x3=0xDEADBEEF while ID decodes add x4,x3,x3 (0x00318233) in the same cycle → next cycle idex_rdata1 = idex_rdata2 = 0xDEADBEEF, idex_reg_write=1, idex_alu_op=10.
- lw x1,0(x2) followed by add x5,x1,x0 → stall=1 for exactly one cycle, one bubble appears in ID/EX, then the add enters with idex_rs1=1. lw x1 followed by lui x1,1 → no stall.
- Immediates: sw x1,-4(x2) gives idex_imm=0xFFFFFFFC; beq offset -8 gives 0xFFFFFFF8; jal offset +2048 gives 0x00000800 with idex_jump=1.
- flush asserted during a load-use condition → bubble loaded and stall=0. hold for 3 cycles → ID/EX unchanged and stall=1 throughout.
- WB write to x0 with 0xFFFFFFFF → x0 still reads 0 through both the bypass path and the array. Opcode 0x7F → idex_illegal=1, all other controls 0.
